// File: rtl/alu8b_pkg.sv
// -----------------------------------------------------------------------------
// alu8b_pkg
// Shared definitions for the alu8b arbiter slice:
//   DATA_W / OP_W        : operand and opcode widths of alu8b
//   arb_state_e          : arbiter FSM states (IDLE, WAIT, RESP)
//   ALU_OP_RST / ALU_DATA_RST : reset values of the registered ALU drive
//   wrap_inc()           : modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package alu8b_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [OP_W-1:0]   ALU_OP_RST   = '0;
  localparam logic [DATA_W-1:0] ALU_DATA_RST = '0;

  // (v + 1) mod n for 0 <= v < n
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/alu8b_rr_pick.sv
// -----------------------------------------------------------------------------
// alu8b_rr_pick
// Combinational round-robin picker: finds the first set bit of valid_i
// searching upward from ptr_i, modulo NREQ.
// Optional feature macro: ALU_ARB_PRIO0_EN -- when defined, requester 0 wins
// whenever it is valid and the round-robin search covers requesters 1..NREQ-1.
// Ports:
//   ptr_i   : search start index
//   valid_i : per-requester valid
//   gnt_o   : one-hot grant (all zero when nothing is valid)
//   idx_o   : index of the granted requester
//   any_o   : at least one requester is valid
// -----------------------------------------------------------------------------
module alu8b_rr_pick
  import alu8b_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [NREQ-1:0]  valid_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef ALU_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    if (PRIO0 && valid_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      // With priority-0 enabled, requester 0 is excluded from the rotation.
      if (!found && valid_i[IDX_W'(cand)] && (!PRIO0 || cand != 0)) begin
        gnt_o[IDX_W'(cand)] = 1'b1;
        idx_o               = IDX_W'(cand);
        found               = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu8b_arbiter.sv
// -----------------------------------------------------------------------------
// alu8b_arbiter
// Shares one registered alu8b between NREQ requesters. One operation is in
// flight at a time: IDLE grants a requester and registers its payload onto the
// ALU inputs, WAIT covers the ALU latency (ALU_LAT+1 cycles), RESP presents the
// captured result until the granted requester accepts it.
// Optional feature macro: ALU_ARB_PRIO0_EN (requester 0 has fixed priority,
// the pointer then only advances on grants to requesters 1..NREQ-1).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake (ready one-hot)
//   req_opcode/a/b      : packed payloads, requester i on [8i+7:8i]
//   rsp_valid/rsp_ready : per-requester response handshake (valid one-hot)
//   rsp_z               : captured ALU result, common to all requesters
//   alu_opcode/a/b      : registered drive to alu8b
//   alu_z               : alu8b result
//   busy                : FSM not in IDLE
// -----------------------------------------------------------------------------
module alu8b_arbiter
  import alu8b_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_opcode,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_z,
  output logic [OP_W-1:0]        alu_opcode,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  input  logic [DATA_W-1:0]      alu_z,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

`ifdef ALU_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_z_q, rsp_z_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  alu8b_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .ptr_i   (ptr_q),
    .valid_i (req_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in IDLE a valid pick is always an accepted handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)              state_d = WAIT;
      WAIT:    if (cnt_q == '0)           state_d = RESP;
      RESP:    if (rsp_ready[gnt_q])      state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Outputs; req_ready is also held low while reset is asserted
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (state_q == IDLE && rst_n) req_ready = pick_gnt;
    if (state_q == RESP)          rsp_valid = NREQ'(1) << gnt_q;
  end

  // Datapath and bookkeeping next-state
  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rsp_z_d  = rsp_z_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_idx;
          cnt_d    = CNT_W'(ALU_LAT);
          alu_op_d = req_opcode[int'(pick_idx)*OP_W +: OP_W];
          alu_a_d  = req_a[int'(pick_idx)*DATA_W +: DATA_W];
          alu_b_d  = req_b[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      WAIT: begin
        // alu_z reflects the held inputs once the count has run out
        if (cnt_q == '0) rsp_z_d = alu_z;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready[gnt_q] && !(PRIO0 && gnt_q == '0))
          ptr_d = IDX_W'(wrap_inc(int'(gnt_q), NREQ));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      rsp_z_q  <= ALU_DATA_RST;
      alu_op_q <= ALU_OP_RST;
      alu_a_q  <= ALU_DATA_RST;
      alu_b_q  <= ALU_DATA_RST;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rsp_z_q  <= rsp_z_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  assign rsp_z      = rsp_z_q;
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: doc/alu8b_arbiter.md
# alu8b_arbiter

Sequencer and arbiter that shares a single `alu8b` instance between `NREQ` requesters. Each requester presents an opcode and two 8-bit operands on a valid/ready channel. The arbiter grants one requester at a time in round-robin order, drives the ALU inputs, waits the ALU's fixed latency, and returns the captured `z` on that requester's response channel. One operation is in flight at a time. The block sits between the requester fabric and `alu8b`, and shares `clk` and `rst_n` with it.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ALU_LAT`, 1: number of `clk` edges from stable ALU inputs to updated `z`. `alu8b` registers `z`, so the value is 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept, at most one bit high.
- `req_opcode` in 8*NREQ: opcode, with requester i on bits [8i+7:8i].
- `req_a`, `req_b` in 8*NREQ: operands, packed like `req_opcode`.
- `rsp_valid` out NREQ: one-hot result valid.
- `rsp_ready` in NREQ: per-requester result accept.
- `rsp_z` out 8: result, common to all requesters.
- `alu_opcode`, `alu_a`, `alu_b` out 8 each: registered drive to `alu8b`.
- `alu_z` in 8: `alu8b` output `z`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - The picker selects grant g, the first i with `req_valid[i]` set, searching from `ptr` upward modulo NREQ.
  - `req_ready[g]` = 1, combinational; all other `req_ready` bits are 0.
  - On `req_valid[g] & req_ready[g]`: register the slice-g opcode/a/b into `alu_*`, latch g, set `cnt` = ALU_LAT, go to WAIT.
- **WAIT**
  - `cnt` decrements each edge.
  - At the edge where `cnt` == 0: `rsp_z` <= `alu_z`, go to RESP.
  - WAIT lasts ALU_LAT+1 cycles.
- **RESP**
  - `rsp_valid[g]` = 1.
  - On `rsp_ready[g]`: clear `rsp_valid`, set `ptr` = (g+1) mod NREQ, go to IDLE.
  - `rsp_ready` bits other than bit g are ignored.
- Opcodes are opaque; no decoding or checking. Operands are passed unmodified.
- `alu_*` hold their last value outside IDLE-accept edges, so the ALU inputs stay stable through WAIT.
- Requesters hold valid and payload until ready. The arbiter samples the payload only on the handshake edge.
- A `req_valid` that drops before grant is not an error; it simply loses arbitration.

## Timing
- **Reset (async assert):** state IDLE, `ptr` = 0, `cnt` = 0, g = 0. `req_ready` = 0 (IDLE with no valid request), `rsp_valid` = 0, `rsp_z` = 0, `alu_opcode`/`alu_a`/`alu_b` = 0, `busy` = 0.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. Requesters re-issue.
- **Latency:** handshake edge E0; ALU inputs valid after E0; `alu8b` updates `z` at E(ALU_LAT); `rsp_z` captured at E(ALU_LAT+1); `rsp_valid` high from then on.
- **Back-to-back throughput:** with `rsp_ready` tied high, one operation per ALU_LAT+3 cycles. That is 4 cycles for ALU_LAT=1: accept, 2×WAIT, RESP, then at least one IDLE cycle.
- **No accept outside IDLE:** a response handshake and a new request accept never occur on the same edge.
- **All requesters valid:** each is served exactly once per NREQ grants.
- **`ptr` wrap:** from NREQ-1 to 0.
- **Reset release:** synchronous to `clk`; the first accept is possible at the first edge after `rst_n` rises.

## Configuration
- `ALU_ARB_PRIO0_EN` defined: requester 0 wins in IDLE whenever `req_valid[0]` is set. Requesters 1..NREQ-1 round-robin among themselves. `ptr` advances only on grants to nonzero requesters.
- Undefined: plain round-robin over all NREQ requesters, as above.

## Structure
- Package `alu8b_pkg`:
  - `DATA_W` = 8 and `OP_W` = 8.
  - State enum {IDLE, WAIT, RESP}.
  - Reset constants for `alu_*` outputs.
- Sub-module `alu8b_rr_pick`: combinational `ptr` + `req_valid` -> one-hot grant and index. The `ALU_ARB_PRIO0_EN` override lives here.
- `alu8b` is instantiated by the parent, not inside the arbiter.

## Test plan
- **Reset:** assert `rst_n`=0 with `req_valid`=4'b1111 -> all outputs 0. After release, first grant goes to requester 0.
- **Single request:** req 2, opcode 8'h63, a=8'd15, b=8'd7 at E0.
  - `alu_*` = 63/0F/07 after E0.
  - `rsp_valid` = 4'b0100 after E2.
  - `rsp_z` equals the `alu_z` sampled at E2.
- **All four valid continuously, `rsp_ready`=1:** grant order 0,1,2,3,0. One accept every 4 cycles. `req_ready` is never multi-hot.
- **Response back-pressure:** hold `rsp_ready[1]`=0 for 5 cycles -> `rsp_valid`/`rsp_z` stable, no `req_ready` asserted, `busy`=1. Release -> IDLE on the next cycle.
- **Reset mid-operation:** drop `rst_n` during WAIT with opcode 8'h8A, a=8'd1 -> no `rsp_valid`. `ptr` returns to 0.
- **With `ALU_ARB_PRIO0_EN`:** req 0 re-asserts after every grant while reqs 1..3 stay valid -> grants 0,0,0…. With req 0 idle, grants follow 1,2,3.
